ui_layer_compositor: RTL and testbench

//  Per-pixel arbiter for the VGA render path. Each cycle it picks which sprite/UI

---
 rtl/ui_layer_compositor_if.sv | 31 +++
 rtl/ui_layer_compositor.sv | 170 +++++++++++++++++
 tb/tb_ui_layer_compositor.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ui_layer_compositor_if.sv
// Pixel-stream bundle between the layer renderers and the compositor:
// per-layer pixel requests and syncs in, composited pixel and syncs out.
interface ui_layer_compositor_if #(
  parameter int NUM_LAYERS = 4
);
  localparam int IW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic                       de_in;
  logic                       hsync_in;
  logic                       vsync_in;
  logic [NUM_LAYERS-1:0]      layer_valid;
  logic [NUM_LAYERS-1:0]      layer_en;
  logic [NUM_LAYERS*24-1:0]   layer_rgb;

  logic                       de_out;
  logic                       hsync_out;
  logic                       vsync_out;
  logic [23:0]                rgb_out;
  logic [IW-1:0]              win_idx;
  logic                       win_valid;

  modport master (
    output de_in, hsync_in, vsync_in, layer_valid, layer_en, layer_rgb,
    input  de_out, hsync_out, vsync_out, rgb_out, win_idx, win_valid
  );

  modport slave (
    input  de_in, hsync_in, vsync_in, layer_valid, layer_en, layer_rgb,
    output de_out, hsync_out, vsync_out, rgb_out, win_idx, win_valid
  );
endinterface

// File: rtl/ui_layer_compositor.sv
// Two-stage per-pixel layer arbiter with transparent-key skip, background fill
// and a vsync-counted flash scheduler that can blink one layer.
module ui_layer_hit #(
  parameter logic [23:0] TRANSP_KEY = 24'hFF00FF
) (
  input  logic        valid,
  input  logic        en,
  input  logic        hide,
  input  logic [23:0] rgb,
  output logic        hit
);
  assign hit = valid & en & (rgb != TRANSP_KEY) & ~hide;
endmodule

module ui_layer_compositor #(
  parameter int          NUM_LAYERS   = 4,
  parameter logic [23:0] TRANSP_KEY   = 24'hFF00FF,
  parameter logic [23:0] BG_COLOR     = 24'h5DADE2,
  parameter int          FLASH_FRAMES = 8,
  parameter int          FLASH_CYCLES = 3,
  localparam int         IW           = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  ui_layer_compositor_if.slave    bus,
  input  logic                    flash_req,
  input  logic [IW-1:0]           flash_layer,
  output logic                    flash_busy
);
  typedef logic [23:0] rgb_t;
  typedef enum logic [1:0] {IDLE, ON, OFF} fstate_t;

  localparam int STAGES = 2;
  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int CW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

  // {de, hsync, vsync} per pipeline stage
  logic [STAGES-1:0][2:0]       sync_pipe;
  logic [NUM_LAYERS-1:0][23:0]  rgb_q;
  logic [NUM_LAYERS-1:0]        hit_d, hit_q;
  logic                         vs_hist, tick;

  fstate_t        state, state_nx;
  logic [FW-1:0]  frame_cnt, frame_nx;
  logic [CW-1:0]  cyc_cnt, cyc_nx;
  logic [IW-1:0]  flash_layer_q, layer_nx;
  logic           flash_hide, req_ok;

  assign flash_hide = (state == OFF);
  assign flash_busy = (state != IDLE);
  assign req_ok     = (int'(flash_layer) < NUM_LAYERS);
  assign tick       = vs_hist & ~sync_pipe[0][0];

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_lane
    ui_layer_hit #(.TRANSP_KEY(TRANSP_KEY)) u_hit (
      .valid (bus.layer_valid[g]),
      .en    (bus.layer_en[g]),
      .hide  (flash_hide && (flash_layer_q == IW'(g))),
      .rgb   (bus.layer_rgb[24*g +: 24]),
      .hit   (hit_d[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_pipe <= '0;
      rgb_q     <= '0;
      hit_q     <= '0;
      vs_hist   <= 1'b1;
    end else begin
      sync_pipe <= {sync_pipe[STAGES-2:0], {bus.de_in, bus.hsync_in, bus.vsync_in}};
      rgb_q     <= bus.layer_rgb;
      hit_q     <= hit_d;
      vs_hist   <= sync_pipe[0][0];
    end
  end

  // Loop runs high-to-low so the lowest-index hit is the final assignment.
  logic          found;
  logic [IW-1:0] win_d;
  always_comb begin
    found = 1'b0;
    win_d = '0;
    for (int i = NUM_LAYERS-1; i >= 0; i--) begin
      if (hit_q[i]) begin
        found = 1'b1;
        win_d = IW'(i);
      end
    end
  end

  rgb_t rgb_r;
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_r         <= '0;
      bus.win_idx   <= '0;
      bus.win_valid <= 1'b0;
    end else if (!sync_pipe[0][2]) begin
      rgb_r         <= '0;
      bus.win_idx   <= '0;
      bus.win_valid <= 1'b0;
    end else if (found) begin
      rgb_r         <= rgb_q[win_d];
      bus.win_idx   <= win_d;
      bus.win_valid <= 1'b1;
    end else begin
      rgb_r         <= BG_COLOR;
      bus.win_idx   <= '0;
      bus.win_valid <= 1'b0;
    end
  end

  assign bus.rgb_out   = rgb_r;
  assign bus.de_out    = sync_pipe[STAGES-1][2];
  assign bus.hsync_out = sync_pipe[STAGES-1][1];
  assign bus.vsync_out = sync_pipe[STAGES-1][0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      frame_cnt     <= '0;
      cyc_cnt       <= '0;
      flash_layer_q <= '0;
    end else begin
      state         <= state_nx;
      frame_cnt     <= frame_nx;
      cyc_cnt       <= cyc_nx;
      flash_layer_q <= layer_nx;
    end
  end

  // Ticks are ignored in IDLE, so a request coinciding with a tick starts fresh.
  always_comb begin
    state_nx = state;
    frame_nx = frame_cnt;
    cyc_nx   = cyc_cnt;
    layer_nx = flash_layer_q;
    case (state)
      IDLE: if (flash_req && req_ok) begin
        state_nx = ON;
        frame_nx = '0;
        cyc_nx   = '0;
        layer_nx = flash_layer;
      end
      ON: if (tick) begin
        if (frame_cnt == FW'(FLASH_FRAMES-1)) begin
          state_nx = OFF;
          frame_nx = '0;
        end else begin
          frame_nx = frame_cnt + 1'b1;
        end
      end
      OFF: if (tick) begin
        if (frame_cnt == FW'(FLASH_FRAMES-1)) begin
          frame_nx = '0;
          if (cyc_cnt == CW'(FLASH_CYCLES-1)) begin
            state_nx = IDLE;
            cyc_nx   = '0;
          end else begin
            state_nx = ON;
            cyc_nx   = cyc_cnt + 1'b1;
          end
        end else begin
          frame_nx = frame_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ui_layer_compositor.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares them when their due cycle arrives.
module tb_ui_layer_compositor;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flash_req = 1'b0;
  logic [1:0] flash_layer = '0;
  logic       flash_busy;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  typedef struct {
    int          due;
    logic        de, hs, vs;
    logic [23:0] rgb;
    logic [1:0]  idx;
    logic        wv;
  } exp_t;

  typedef struct {
    int   due;
    int   kind;   // 0: flash_busy value, 1: everything zero
    logic busy;
  } st_t;

  exp_t pq[$];
  st_t  sq[$];

  ui_layer_compositor_if #(.NUM_LAYERS(4)) ifc();

  ui_layer_compositor #(
    .NUM_LAYERS(4), .TRANSP_KEY(24'hFF00FF), .BG_COLOR(24'h5DADE2),
    .FLASH_FRAMES(2), .FLASH_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(ifc),
    .flash_req(flash_req), .flash_layer(flash_layer), .flash_busy(flash_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t        e;
    st_t         s;
    logic [29:0] got, want;
    while (pq.size() > 0 && pq[0].due <= cyc) begin
      e    = pq.pop_front();
      got  = {ifc.de_out, ifc.hsync_out, ifc.vsync_out, ifc.rgb_out, ifc.win_idx, ifc.win_valid};
      want = {e.de, e.hs, e.vs, e.rgb, e.idx, e.wv};
      n_chk++;
      if (got !== want || e.due != cyc) begin
        n_fail++;
        $display("FAIL pixel cyc=%0d due=%0d got de/hs/vs=%b%b%b rgb=%h idx=%0d wv=%b want de/hs/vs=%b%b%b rgb=%h idx=%0d wv=%b",
                 cyc, e.due, got[29], got[28], got[27], got[26:3], got[2:1], got[0],
                 e.de, e.hs, e.vs, e.rgb, e.idx, e.wv);
      end
    end
    while (sq.size() > 0 && sq[0].due <= cyc) begin
      s = sq.pop_front();
      n_chk++;
      if (s.kind == 1) begin
        got = {ifc.de_out, ifc.hsync_out, ifc.vsync_out, ifc.rgb_out, ifc.win_idx, ifc.win_valid};
        if (got !== 30'd0 || flash_busy !== 1'b0 || s.due != cyc) begin
          n_fail++;
          $display("FAIL reset_state cyc=%0d got outs=%h busy=%b want outs=0 busy=0", cyc, got, flash_busy);
        end
      end else if (flash_busy !== s.busy || s.due != cyc) begin
        n_fail++;
        $display("FAIL flash_busy cyc=%0d got %b want %b", cyc, flash_busy, s.busy);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_busy(input logic b);
    st_t s;
    s.due = cyc; s.kind = 0; s.busy = b;
    sq.push_back(s);
  endtask

  task automatic px(input logic de, hs, vs, input logic [3:0] v,
                    input logic [23:0] r0, r1, r2, r3,
                    input logic [23:0] er, input logic [1:0] ei, input logic ev);
    exp_t e;
    ifc.de_in = de; ifc.hsync_in = hs; ifc.vsync_in = vs;
    ifc.layer_valid = v;
    ifc.layer_rgb = {r3, r2, r1, r0};
    e.due = cyc + 2; e.de = de; e.hs = hs; e.vs = vs;
    e.rgb = er; e.idx = ei; e.wv = ev;
    pq.push_back(e);
    step();
  endtask

  // Layer 0 = C0C0C0 (flash target), layer 1 = 112233 (fallthrough).
  task automatic frame(input bit show);
    for (int i = 0; i < 4; i++)
      px(1, 0, 1, 4'b0011, 24'hC0C0C0, 24'h112233, 24'h0, 24'h0,
         show ? 24'hC0C0C0 : 24'h112233, show ? 2'd0 : 2'd1, 1'b1);
    px(0, 1, 0, 4'b0011, 24'hC0C0C0, 24'h112233, 24'h0, 24'h0, 24'h0, 2'd0, 1'b0);
    px(0, 0, 1, 4'b0011, 24'hC0C0C0, 24'h112233, 24'h0, 24'h0, 24'h0, 2'd0, 1'b0);
    px(0, 0, 1, 4'b0011, 24'hC0C0C0, 24'h112233, 24'h0, 24'h0, 24'h0, 2'd0, 1'b0);
  endtask

  task automatic flash_pulse(input logic [1:0] layer);
    flash_req = 1'b1;
    flash_layer = layer;
    px(0, 0, 1, 4'b0011, 24'hC0C0C0, 24'h112233, 24'h0, 24'h0, 24'h0, 2'd0, 1'b0);
    flash_req = 1'b0;
  endtask

  initial begin
    st_t s;
    logic d, h, v;
    ifc.layer_en = 4'hF;
    #1;
    for (int i = 0; i < 3; i++) begin
      ifc.de_in = 1'($urandom); ifc.hsync_in = 1'($urandom); ifc.vsync_in = 1'($urandom);
      ifc.layer_valid = 4'($urandom); ifc.layer_en = 4'($urandom);
      ifc.layer_rgb = {$urandom, $urandom, $urandom};
      flash_req = 1'($urandom); flash_layer = 2'($urandom);
      step();
    end
    s.due = cyc; s.kind = 1; s.busy = 1'b0;
    sq.push_back(s);
    flash_req = 1'b0;
    ifc.layer_en = 4'hF;
    reset = 1'b0;

    // priority, transparency, background, blanking, enable mask
    px(1, 0, 1, 4'b1010, 24'h0, 24'hFFCC00, 24'h0, 24'h202020, 24'hFFCC00, 2'd1, 1'b1);
    px(1, 0, 1, 4'b0101, 24'hFF00FF, 24'h0, 24'hFF99CC, 24'h0, 24'hFF99CC, 2'd2, 1'b1);
    px(1, 0, 1, 4'b0000, 24'h1, 24'h2, 24'h3, 24'h4, 24'h5DADE2, 2'd0, 1'b0);
    px(0, 0, 1, 4'b1111, 24'h1, 24'h2, 24'h3, 24'h4, 24'h000000, 2'd0, 1'b0);
    px(1, 1, 1, 4'b1111, 24'h123456, 24'h2, 24'h3, 24'h4, 24'h123456, 2'd0, 1'b1);
    px(1, 0, 1, 4'b1111, 24'hFF00FF, 24'hFF00FF, 24'hFF00FF, 24'hFF00FF, 24'h5DADE2, 2'd0, 1'b0);
    px(1, 0, 1, 4'b1111, 24'hFF00FF, 24'hFF00FF, 24'hFF00FF, 24'h000000, 24'h000000, 2'd3, 1'b1);
    ifc.layer_en = 4'b1101;
    px(1, 0, 1, 4'b1010, 24'h0, 24'hFFCC00, 24'h0, 24'h202020, 24'h202020, 2'd3, 1'b1);
    ifc.layer_en = 4'hF;

    // sync pass-through with random de/hsync/vsync
    for (int i = 0; i < 20; i++) begin
      d = 1'($urandom); h = 1'($urandom); v = 1'($urandom);
      px(d, h, v, 4'b0000, 24'h0, 24'h0, 24'h0, 24'h0, d ? 24'h5DADE2 : 24'h0, 2'd0, 1'b0);
    end
    for (int i = 0; i < 3; i++)
      px(0, 0, 1, 4'b0000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 2'd0, 1'b0);

    // flash layer 0, with an ignored request for layer 2 while busy
    chk_busy(1'b0);
    flash_pulse(2'd0);
    chk_busy(1'b1);
    frame(1);
    flash_pulse(2'd2);
    frame(1);
    frame(0);
    frame(0);
    chk_busy(1'b1);
    frame(1);
    frame(1);
    frame(0);
    frame(0);
    frame(1);
    chk_busy(1'b0);

    // reset while the layer is hidden
    flash_pulse(2'd0);
    frame(1);
    frame(1);
    frame(0);
    chk_busy(1'b1);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_busy(1'b0);
    for (int i = 0; i < 3; i++)
      px(1, 0, 1, 4'b0011, 24'hC0C0C0, 24'h112233, 24'h0, 24'h0, 24'hC0C0C0, 2'd0, 1'b1);
    px(0, 0, 1, 4'b0000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 2'd0, 1'b0);

    repeat (5) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + pq.size() + sq.size());
    $finish;
  end
endmodule
